fuvrf_config_writer: RTL and testbench



---
 rtl/lebug_cfg_pkg.sv | 24 ++
 rtl/fuvrf_config_writer.sv | 177 +++++++++++++++++
 tb/tb_fuvrf_config_writer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lebug_cfg_pkg.sv
// Shared definitions for the configuration-side writers: command opcodes
// and the command-decoder state encoding.
package lebug_cfg_pkg;

  localparam logic [7:0] CFG_SET_OP     = 8'h01;
  localparam logic [7:0] CFG_SET_ADDR   = 8'h02;
  localparam logic [7:0] CFG_SET_AXIS   = 8'h03;
  localparam logic [7:0] CFG_LOAD_FUVRF = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    CHAIN,
    VALUE,
    ADDR,
    DATA,
    COMMIT
  } cfg_state_t;

  // Opcodes that address a per-chain firmware register (chain + value follow).
  function automatic logic is_chain_opcode(input logic [7:0] op);
    return (op == CFG_SET_OP) || (op == CFG_SET_ADDR) || (op == CFG_SET_AXIS);
  endfunction

endpackage

// File: rtl/fuvrf_config_writer.sv
// Configuration writer for the filter/reduce stage. Decodes the byte-wide
// config stream addressed to this unit, updates the per-chain firmware
// registers and assembles threshold words for FUVRF port b.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an opcode byte
// CHAIN  | waiting for the chain index of a SET_OP/SET_ADDR/SET_AXIS
// VALUE  | waiting for the register value for the latched chain
// ADDR   | waiting for the FUVRF entry index of a LOAD_FUVRF
// DATA   | shifting in WORD_BYTES payload bytes, first byte ends up MSB
// COMMIT | port-b write pulse in flight; matching bytes are refused
module fuvrf_config_writer
  import lebug_cfg_pkg::*;
#(
  parameter int M                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int FUVRF_SIZE         = 4,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_FILTER_OP   = '0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_FILTER_ADDR = '0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE_REDUCE_AXIS = '0,
  localparam int MEM_WIDTH  = M * DATA_WIDTH,
  localparam int WORD_BYTES = MEM_WIDTH / 8,
  localparam int AW         = (FUVRF_SIZE > 1) ? $clog2(FUVRF_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tracing,
  input  logic                         config_valid,
  input  logic [7:0]                   configId,
  input  logic [7:0]                   configData,
  output logic [MAX_CHAINS-1:0][7:0]   firmware_filter_op,
  output logic [MAX_CHAINS-1:0][7:0]   firmware_filter_addr,
  output logic [MAX_CHAINS-1:0][7:0]   firmware_reduce_axis,
  output logic [AW-1:0]                fuvrf_address_b,
  output logic [MEM_WIDTH-1:0]         fuvrf_data_b,
  output logic                         fuvrf_wren_b,
  output logic                         busy,
  output logic                         cfg_error
);

  localparam int CW    = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int CNT_W = $clog2(WORD_BYTES) + 1;

  localparam logic [7:0]       MY_ID       = 8'(PERSONAL_CONFIG_ID);
  localparam logic [7:0]       CHAIN_LIMIT = 8'(MAX_CHAINS);
  localparam logic [7:0]       ENTRY_LIMIT = 8'(FUVRF_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(WORD_BYTES - 1);

  cfg_state_t           state;
  logic [CNT_W-1:0]     byte_cnt;
  logic [MEM_WIDTH-1:0] shift;
  logic [MEM_WIDTH-1:0] shift_next;
  logic [7:0]           cmd_op;
  logic [CW-1:0]        chain_sel;
  logic [AW-1:0]        entry_sel;

  logic hit;
  logic refuse;
  logic take;

  // A matching byte is refused while tracing or while the write pulse is out;
  // refused bytes never advance the decoder.
  assign hit        = config_valid && (configId == MY_ID);
  assign refuse     = tracing || (state == COMMIT);
  assign take       = hit && !refuse;
  assign shift_next = {shift[MEM_WIDTH-9:0], configData};

  // Command decoder, firmware registers and port-b write generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      byte_cnt             <= '0;
      shift                <= '0;
      cmd_op               <= '0;
      chain_sel            <= '0;
      entry_sel            <= '0;
      fuvrf_wren_b         <= 1'b0;
      fuvrf_address_b      <= '0;
      fuvrf_data_b         <= '0;
      busy                 <= 1'b0;
      cfg_error            <= 1'b0;
      firmware_filter_op   <= INITIAL_FIRMWARE_FILTER_OP;
      firmware_filter_addr <= INITIAL_FIRMWARE_FILTER_ADDR;
      firmware_reduce_axis <= INITIAL_FIRMWARE_REDUCE_AXIS;
    end else begin
      cfg_error    <= hit && refuse;
      fuvrf_wren_b <= 1'b0;

      case (state)
        IDLE: begin
          if (take) begin
            if (is_chain_opcode(configData)) begin
              cmd_op <= configData;
              state  <= CHAIN;
              busy   <= 1'b1;
            end else if (configData == CFG_LOAD_FUVRF) begin
              cmd_op <= configData;
              state  <= ADDR;
              busy   <= 1'b1;
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end

        CHAIN: begin
          if (take) begin
            if (configData >= CHAIN_LIMIT) begin
              cfg_error <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              chain_sel <= configData[CW-1:0];
              state     <= VALUE;
            end
          end
        end

        VALUE: begin
          if (take) begin
            case (cmd_op)
              CFG_SET_OP:   firmware_filter_op[chain_sel]   <= configData;
              CFG_SET_ADDR: firmware_filter_addr[chain_sel] <= configData;
              CFG_SET_AXIS: firmware_reduce_axis[chain_sel] <= configData;
              default:      ;
            endcase
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        ADDR: begin
          if (take) begin
            if (configData >= ENTRY_LIMIT) begin
              cfg_error <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              entry_sel <= configData[AW-1:0];
              byte_cnt  <= '0;
              state     <= DATA;
            end
          end
        end

        DATA: begin
          if (take) begin
            shift    <= shift_next;
            byte_cnt <= byte_cnt + 1'b1;
            // The pulse is launched with the last byte so the RAM sees
            // wren_b for exactly the COMMIT cycle.
            if (byte_cnt == LAST_CNT) begin
              fuvrf_wren_b    <= 1'b1;
              fuvrf_address_b <= entry_sel;
              fuvrf_data_b    <= shift_next;
              state           <= COMMIT;
            end
          end
        end

        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fuvrf_config_writer.sv
// Randomised bench for fuvrf_config_writer against a command-level model:
// accepted bytes are collected per command and applied once complete.
module tb_fuvrf_config_writer;

  localparam int M   = 8;
  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int FS  = 4;
  localparam int MW  = M * DW;
  localparam int WB  = MW / 8;
  localparam int PID = 0;

  localparam logic [NC-1:0][7:0] INIT_OP   = 32'h0000_0001;
  localparam logic [NC-1:0][7:0] INIT_ADDR = 32'h0302_0100;
  localparam logic [NC-1:0][7:0] INIT_AXIS = 32'h0A0B_0C0D;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 tracing = 1'b0;
  logic                 config_valid = 1'b0;
  logic [7:0]           configId = 8'h00;
  logic [7:0]           configData = 8'h00;
  logic [NC-1:0][7:0]   firmware_filter_op;
  logic [NC-1:0][7:0]   firmware_filter_addr;
  logic [NC-1:0][7:0]   firmware_reduce_axis;
  logic [1:0]           fuvrf_address_b;
  logic [MW-1:0]        fuvrf_data_b;
  logic                 fuvrf_wren_b;
  logic                 busy;
  logic                 cfg_error;

  fuvrf_config_writer #(
    .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(NC), .PERSONAL_CONFIG_ID(PID),
    .FUVRF_SIZE(FS),
    .INITIAL_FIRMWARE_FILTER_OP(INIT_OP),
    .INITIAL_FIRMWARE_FILTER_ADDR(INIT_ADDR),
    .INITIAL_FIRMWARE_REDUCE_AXIS(INIT_AXIS)
  ) dut (
    .clk(clk), .reset(reset), .tracing(tracing),
    .config_valid(config_valid), .configId(configId), .configData(configData),
    .firmware_filter_op(firmware_filter_op),
    .firmware_filter_addr(firmware_filter_addr),
    .firmware_reduce_axis(firmware_reduce_axis),
    .fuvrf_address_b(fuvrf_address_b), .fuvrf_data_b(fuvrf_data_b),
    .fuvrf_wren_b(fuvrf_wren_b), .busy(busy), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wren_seen = 0;

  // reference model state
  logic [7:0]    q[$];
  logic [7:0]    m_op[NC];
  logic [7:0]    m_addr[NC];
  logic [7:0]    m_axis[NC];
  logic [1:0]    m_waddr;
  logic [MW-1:0] m_wdata;
  bit            m_commit;
  bit            e_err;
  bit            e_wren;
  bit            e_busy;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < NC; c++) begin
      m_op[c]   = INIT_OP[c];
      m_addr[c] = INIT_ADDR[c];
      m_axis[c] = INIT_AXIS[c];
    end
    m_waddr  = '0;
    m_wdata  = '0;
    m_commit = 0;
    e_err    = 0;
    e_wren   = 0;
    e_busy   = 0;
  endtask

  // One clock edge of the command-level model.
  task automatic model_edge(input bit v, input logic [7:0] id, input logic [7:0] d, input bit tr);
    bit was_commit;
    logic [7:0] op;
    e_err      = 0;
    e_wren     = 0;
    was_commit = m_commit;
    m_commit   = 0;
    if (v && id == 8'(PID)) begin
      if (tr || was_commit) begin
        e_err = 1;
      end else begin
        q.push_back(d);
        op = q[0];
        if (q.size() == 1) begin
          if (op < 8'd1 || op > 8'd4) begin
            e_err = 1;
            q.delete();
          end
        end else if (op != 8'd4) begin
          if (q.size() == 2) begin
            if (q[1] >= 8'(NC)) begin
              e_err = 1;
              q.delete();
            end
          end else begin
            if (op == 8'd1) m_op[q[1]] = q[2];
            else if (op == 8'd2) m_addr[q[1]] = q[2];
            else m_axis[q[1]] = q[2];
            q.delete();
          end
        end else begin
          if (q.size() == 2) begin
            if (q[1] >= 8'(FS)) begin
              e_err = 1;
              q.delete();
            end
          end else if (q.size() == 2 + WB) begin
            m_wdata = '0;
            for (int i = 0; i < WB; i++) m_wdata[MW-1-8*i -: 8] = q[2+i];
            m_waddr  = q[1][1:0];
            e_wren   = 1;
            m_commit = 1;
            q.delete();
          end
        end
      end
    end
    e_busy = (q.size() != 0) || m_commit;
  endtask

  task automatic compare_all();
    logic [NC*8-1:0] vo, va, vx;
    for (int c = 0; c < NC; c++) begin
      vo[c*8 +: 8] = m_op[c];
      va[c*8 +: 8] = m_addr[c];
      vx[c*8 +: 8] = m_axis[c];
    end
    if (fuvrf_wren_b === 1'b1) wren_seen++;
    chk("cfg_error", cfg_error, e_err);
    chk("wren_b", fuvrf_wren_b, e_wren);
    chk("busy", busy, e_busy);
    chk("address_b", fuvrf_address_b, m_waddr);
    chk("data_b", fuvrf_data_b, m_wdata);
    chk("filter_op", firmware_filter_op, vo);
    chk("filter_addr", firmware_filter_addr, va);
    chk("reduce_axis", firmware_reduce_axis, vx);
  endtask

  task automatic tick(input bit v, input logic [7:0] id, input logic [7:0] d, input bit tr);
    config_valid = v;
    configId     = id;
    configData   = d;
    tracing      = tr;
    @(posedge clk);
    model_edge(v, id, d, tr);
    #1;
    compare_all();
  endtask

  task automatic idle();
    tick(0, 8'h00, 8'h00, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic apply_reset();
    config_valid = 0;
    tracing      = 0;
    reset        = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit noisy);
    int g;
    if (noisy) begin
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        if ($urandom_range(0, 3) == 0)
          tick(1, 8'($urandom_range(1, 255)), 8'($urandom), 0);
        else
          tick(0, 8'h00, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 15) == 0) tick(1, 8'(PID), d, 1);
    end
    tick(1, 8'(PID), d, 0);
  endtask

  task automatic random_cmd();
    int k;
    int n;
    logic [7:0] a;
    k = $urandom_range(0, 9);
    if (k < 6) begin
      send_byte(8'($urandom_range(1, 3)), 1);
      send_byte(8'($urandom_range(0, (k == 5) ? 6 : 3)), 1);
      send_byte(8'($urandom), 1);
    end else if (k < 8) begin
      a = 8'($urandom_range(0, (k == 7) ? 5 : 3));
      send_byte(8'h04, 1);
      send_byte(a, 1);
      if (a < 8'(FS))
        for (int i = 0; i < WB; i++) send_byte(8'($urandom), 1);
    end else if (k == 8) begin
      send_byte(8'($urandom_range(5, 255)), 1);
    end else begin
      n = $urandom_range(0, WB - 1);
      send_byte(8'h04, 1);
      send_byte(8'($urandom_range(0, 3)), 1);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 1);
      apply_reset();
    end
  endtask

  initial begin
    model_reset();
    #2;
    apply_reset();
    chk("rst_chain0_op", firmware_filter_op[0], 8'h01);

    // SET_OP chain 2 := 1
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    chk("plan_op2", firmware_filter_op[2], 8'h01);
    idle();

    // LOAD_FUVRF entry 3 with 0x00..0x1F
    wren_seen = 0;
    send_byte(8'h04, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < WB; i++) send_byte(8'(i), 0);
    chk("plan_addr", fuvrf_address_b, 2'd3);
    chk("plan_data_hi", fuvrf_data_b[MW-1 -: 8], 8'h00);
    chk("plan_data_lo", fuvrf_data_b[7:0], 8'h1F);
    idle();
    idle();
    chk("plan_wren_cnt", wren_seen, 1);

    // rejected commands
    send_byte(8'h07, 0);
    idle();
    send_byte(8'h02, 0);
    send_byte(8'h05, 0);
    idle();
    send_byte(8'h04, 0);
    send_byte(8'h04, 0);
    idle();

    // foreign ID
    tick(1, 8'h01, 8'h01, 0);
    tick(1, 8'h01, 8'h00, 0);
    tick(1, 8'h01, 8'h55, 0);
    idle();

    // tracing mid-DATA drops one byte, then the load completes
    send_byte(8'h04, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 0);
    tick(1, 8'(PID), 8'hA5, 1);
    for (int i = 5; i < WB; i++) send_byte(8'(8'hA0 + i), 0);
    chk("trace_addr", fuvrf_address_b, 2'd2);
    chk("trace_data_lo", fuvrf_data_b[7:0], 8'hBF);
    idle();

    // reset after 10 DATA bytes, then a full load
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
    apply_reset();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < WB; i++) send_byte(8'($urandom), 0);
    idle();

    repeat (250) random_cmd();
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
